// File: rtl/jtcop_objdma.sv
// Object RAM copy DMA: takes the 68000 bus through BR/BG/BGACK and streams
// LEN words from the object RAM window into the line buffer shadow RAM.
module jtcop_objdma #(
  parameter logic [22:0] SRC_ADDR = 23'h18_4000,
  parameter int          LEN      = 1024,
  parameter logic [7:0]  TOUT     = 8'd255
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        copy,
  input  logic        cpu_asn,
  output logic        BRn,
  input  logic        BGn,
  output logic        BGACKn,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RnW,
  output logic [22:0] A,
  input  logic [15:0] din,
  input  logic        DTACKn,
  output logic [10:0] buf_addr,
  output logic [15:0] buf_dout,
  output logic        buf_we,
  output logic        busy,
  output logic        tout_err
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] ADDR  = 3'd2;
  localparam logic [2:0] STRB  = 3'd3;
  localparam logic [2:0] WAIT  = 3'd4;
  localparam logic [2:0] LATCH = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  localparam logic [10:0] LAST = 11'(LEN - 1);

  logic [2:0]  state;
  logic [10:0] cnt;
  logic [7:0]  tcnt;
  logic [7:0]  tcnt_inc;
  logic        pending;
  logic        strb_n;

  assign tcnt_inc = tcnt + 8'd1;
  assign ASn      = strb_n;
  assign UDSn     = strb_n;
  assign LDSn     = strb_n;
  assign RnW      = 1'b1;
  // One clk wide because it is qualified by the same cen that leaves LATCH
  assign buf_we   = cen && (state == LATCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      pending  <= 1'b0;
      BRn      <= 1'b1;
      BGACKn   <= 1'b1;
      strb_n   <= 1'b1;
      A        <= SRC_ADDR;
      buf_addr <= '0;
      buf_dout <= '0;
      busy     <= 1'b0;
      tout_err <= 1'b0;
    end else begin
      // The request may land between cen ticks, so it is captured on every clk
      if (state == IDLE && copy) pending <= 1'b1;
      if (cen) begin
        case (state)
          IDLE: if (pending) begin
            pending  <= 1'b0;
            busy     <= 1'b1;
            tout_err <= 1'b0;
            BRn      <= 1'b0;
            state    <= REQ;
          end
          REQ: if (!BGn && cpu_asn && DTACKn) begin
            BGACKn <= 1'b0;
            BRn    <= 1'b1;
            state  <= ADDR;
          end
          ADDR: begin
            A     <= SRC_ADDR + {12'd0, cnt};
            state <= STRB;
          end
          STRB: begin
            strb_n <= 1'b0;
            tcnt   <= '0;
            state  <= WAIT;
          end
          WAIT: begin
            tcnt <= tcnt_inc;
            if (!DTACKn) begin
              buf_dout <= din;
              buf_addr <= cnt;
              state    <= LATCH;
            end else if (tcnt_inc == TOUT) begin
              buf_dout <= 16'hFFFF;
              buf_addr <= cnt;
              tout_err <= 1'b1;
              state    <= LATCH;
            end
          end
          LATCH: begin
            strb_n <= 1'b1;
            cnt    <= cnt + 11'd1;
            state  <= (cnt == LAST) ? DONE : ADDR;
          end
          DONE: begin
            BGACKn <= 1'b1;
            busy   <= 1'b0;
            A      <= SRC_ADDR;
            cnt    <= '0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jtcop_objdma.sv
// Bench for jtcop_objdma: emulates the 68000 grant logic and a DTACK responder,
// and checks every copy against a word/tick model built from the bus rules.
`timescale 1ns/1ps
module tb_jtcop_objdma;
  localparam logic [22:0] SRC  = 23'h18_4000;
  localparam int          LEN  = 4;
  localparam int          IW   = 2;
  localparam logic [7:0]  TOUT = 8'd8;

  logic        rst, clk, cen, copy, cpu_asn, BGn, DTACKn;
  logic [15:0] din;
  logic        BRn, BGACKn, ASn, UDSn, LDSn, RnW;
  logic [22:0] A;
  logic [10:0] buf_addr;
  logic [15:0] buf_dout;
  logic        buf_we, busy, tout_err;

  int tests = 0;
  int fails = 0;

  // slave/CPU behaviour knobs
  logic [15:0] mem [LEN];
  int          delay [LEN];
  int          nodtack = -1;
  int          grant_delay = 2;
  int          asn_hold = 0;

  // observations
  logic [10:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic [22:0] wq_a[$];
  int          wq_t[$];
  int tick = 0;
  int bgack_fall_t, asn_first_t, busy_fall_t, bgn_fall_t, asn_rise_t;
  int br_falls, asn_falls, asn_nobgack, strb_bad;

  jtcop_objdma #(.SRC_ADDR(SRC), .LEN(LEN), .TOUT(TOUT)) dut (
    .rst(rst), .clk(clk), .cen(cen), .copy(copy), .cpu_asn(cpu_asn),
    .BRn(BRn), .BGn(BGn), .BGACKn(BGACKn), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn),
    .RnW(RnW), .A(A), .din(din), .DTACKn(DTACKn), .buf_addr(buf_addr),
    .buf_dout(buf_dout), .buf_we(buf_we), .busy(busy), .tout_err(tout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [22:0] off;
  assign off = A - SRC;
  assign din = mem[off[IW-1:0]];

  // CPU grant logic, DTACK responder and cen generation
  logic cen_s;
  int   gcnt = 0, hcnt = 0, w = 0, wi;
  logic was_low = 1'b0;
  initial begin
    cen = 1'b0; BGn = 1'b1; cpu_asn = 1'b1; DTACKn = 1'b1;
  end
  always @(posedge clk) begin
    cen_s = cen;
    #1;
    if (cen_s) begin
      tick++;
      if (!cpu_asn) begin
        hcnt++;
        if (hcnt >= asn_hold) begin cpu_asn = 1'b1; asn_rise_t = tick; end
      end
      if (!BRn) begin
        if (BGn) begin
          gcnt++;
          if (gcnt >= grant_delay) begin
            BGn = 1'b0; gcnt = 0; hcnt = 0; bgn_fall_t = tick;
            cpu_asn = (asn_hold == 0);
            if (asn_hold == 0) asn_rise_t = tick;
          end
        end
      end else begin
        BGn = 1'b1; gcnt = 0;
      end
      if (!ASn) begin
        if (was_low) w++;
        was_low = 1'b1;
      end
    end
    if (ASn) begin w = 0; was_low = 1'b0; end
    wi = int'(off[IW-1:0]);
    DTACKn = !(!ASn && wi != nodtack && w >= delay[wi]);
    #1 cen = ($urandom_range(0, 2) != 0);
  end

  logic prev_brn = 1'b1, prev_bgack = 1'b1, prev_asn = 1'b1, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (buf_we) begin
      wq_addr.push_back(buf_addr); wq_data.push_back(buf_dout);
      wq_a.push_back(A); wq_t.push_back(tick);
    end
    if (prev_brn && !BRn) br_falls++;
    if (prev_bgack && !BGACKn) bgack_fall_t = tick;
    if (prev_asn && !ASn) begin
      asn_falls++;
      if (asn_first_t < 0) asn_first_t = tick;
    end
    if (!ASn && BGACKn) asn_nobgack++;
    if (UDSn !== ASn || LDSn !== ASn || RnW !== 1'b1) strb_bad++;
    if (prev_busy && !busy) busy_fall_t = tick;
    prev_brn = BRn; prev_bgack = BGACKn; prev_asn = ASn; prev_busy = busy;
  end

  // reference model: what word i must look like and how many ticks it takes
  function automatic logic [49:0] exp_word(input int i);
    logic [15:0] d;
    d = (i == nodtack) ? 16'hFFFF : mem[i];
    return {11'(i), d, SRC + 23'(i)};
  endfunction
  function automatic int exp_ticks(input int i);
    return (i == nodtack) ? 3 + int'(TOUT) : 4 + delay[i];
  endfunction

  task automatic setup(input bit seq, input int dly, input int nd, input int ah);
    for (int i = 0; i < LEN; i++) begin
      mem[i]   = seq ? 16'(16'h1000 + i) : 16'($urandom);
      delay[i] = (dly < 0) ? int'($urandom_range(0, 2)) : dly;
    end
    nodtack = nd; asn_hold = ah; grant_delay = 2;
  endtask

  task automatic start_copy();
    wq_addr.delete(); wq_data.delete(); wq_a.delete(); wq_t.delete();
    bgack_fall_t = -1; asn_first_t = -1; busy_fall_t = -1; bgn_fall_t = -1; asn_rise_t = -1;
    br_falls = 0; asn_falls = 0; asn_nobgack = 0; strb_bad = 0;
    copy = 1'b1;
    @(negedge clk); #3 copy = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #3;
      if (busy_fall_t >= 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [58:0] got, exp;
    rst = 1'b1; copy = 1'b0;
    repeat (3) @(negedge clk);
    got = {BRn, BGACKn, ASn, UDSn, LDSn, RnW, A, buf_addr, buf_dout, buf_we, busy, tout_err};
    exp = {6'h3F, SRC, 11'd0, 16'd0, 3'd0};
    tests++;
    if (got !== exp) begin fails++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    #2 rst = 1'b0;
    repeat (3) @(negedge clk); #3;
    tests++;
    if (busy !== 1'b0 || BRn !== 1'b1) begin
      fails++; $display("FAIL reset_idle busy=%b BRn=%b exp busy=0 BRn=1", busy, BRn);
    end
  endtask

  task automatic test_basic();
    bit ok; int n; logic [49:0] got, exp;
    setup(1'b1, 0, -1, 0);
    start_copy(); wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done timed out"); end
    tests++; if (wq_addr.size() != LEN) begin fails++; $display("FAIL basic_count got=%0d exp=%0d", wq_addr.size(), LEN); end
    n = (wq_addr.size() < LEN) ? wq_addr.size() : LEN;
    for (int i = 0; i < n; i++) begin
      got = {wq_addr[i], wq_data[i], wq_a[i]}; exp = exp_word(i);
      tests++; if (got !== exp) begin fails++; $display("FAIL basic_word%0d got=%h exp=%h", i, got, exp); end
      if (i > 0) begin
        tests++;
        if (wq_t[i] - wq_t[i-1] != exp_ticks(i)) begin
          fails++; $display("FAIL basic_ticks%0d got=%0d exp=%0d", i, wq_t[i] - wq_t[i-1], exp_ticks(i));
        end
      end
    end
    tests++; if (asn_first_t - bgack_fall_t != 2) begin fails++; $display("FAIL basic_first_as got=%0d exp=2", asn_first_t - bgack_fall_t); end
    tests++; if (bgack_fall_t - bgn_fall_t != 1) begin fails++; $display("FAIL basic_bgack got=%0d exp=1", bgack_fall_t - bgn_fall_t); end
    if (n == LEN) begin
      tests++; if (busy_fall_t - wq_t[LEN-1] != 2) begin fails++; $display("FAIL basic_busy_fall got=%0d exp=2", busy_fall_t - wq_t[LEN-1]); end
    end
    tests++;
    if (BGACKn !== 1'b1 || tout_err !== 1'b0 || br_falls != 1 || strb_bad != 0) begin
      fails++; $display("FAIL basic_end BGACKn=%b tout_err=%b br=%0d strb_bad=%0d exp 1 0 1 0", BGACKn, tout_err, br_falls, strb_bad);
    end
  endtask

  task automatic test_grant_wait();
    bit ok; int n; logic [49:0] got, exp;
    setup(1'b0, 0, -1, 5);
    start_copy(); wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL grant_done timed out"); end
    tests++; if (asn_rise_t - bgn_fall_t != 5) begin fails++; $display("FAIL grant_hold got=%0d exp=5", asn_rise_t - bgn_fall_t); end
    tests++; if (bgack_fall_t != asn_rise_t + 1) begin fails++; $display("FAIL grant_bgack got=%0d exp=%0d", bgack_fall_t, asn_rise_t + 1); end
    tests++; if (asn_nobgack != 0 || asn_first_t - bgack_fall_t != 2) begin
      fails++; $display("FAIL grant_as early=%0d gap=%0d exp 0 2", asn_nobgack, asn_first_t - bgack_fall_t);
    end
    n = (wq_addr.size() < LEN) ? wq_addr.size() : LEN;
    tests++; if (n != LEN) begin fails++; $display("FAIL grant_count got=%0d exp=%0d", wq_addr.size(), LEN); end
    for (int i = 0; i < n; i++) begin
      got = {wq_addr[i], wq_data[i], wq_a[i]}; exp = exp_word(i);
      tests++; if (got !== exp) begin fails++; $display("FAIL grant_word%0d got=%h exp=%h", i, got, exp); end
    end
    asn_hold = 0;
  endtask

  task automatic test_timeout();
    bit ok; int n; logic [49:0] got, exp;
    setup(1'b0, 0, 2, 0);
    start_copy(); wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL tout_done timed out"); end
    n = (wq_addr.size() < LEN) ? wq_addr.size() : LEN;
    tests++; if (n != LEN) begin fails++; $display("FAIL tout_count got=%0d exp=%0d", wq_addr.size(), LEN); end
    for (int i = 0; i < n; i++) begin
      got = {wq_addr[i], wq_data[i], wq_a[i]}; exp = exp_word(i);
      tests++; if (got !== exp) begin fails++; $display("FAIL tout_word%0d got=%h exp=%h", i, got, exp); end
      if (i > 0) begin
        tests++;
        if (wq_t[i] - wq_t[i-1] != exp_ticks(i)) begin
          fails++; $display("FAIL tout_ticks%0d got=%0d exp=%0d", i, wq_t[i] - wq_t[i-1], exp_ticks(i));
        end
      end
    end
    tests++; if (tout_err !== 1'b1 || BGACKn !== 1'b1) begin fails++; $display("FAIL tout_flag tout_err=%b BGACKn=%b exp 1 1", tout_err, BGACKn); end
    nodtack = -1;
  endtask

  task automatic test_back_to_back();
    bit ok; int n; logic [49:0] got, exp;
    for (int r = 0; r < 2; r++) begin
      setup(1'b0, -1, -1, 0);
      start_copy(); wait_done(ok);
      tests++; if (!ok) begin fails++; $display("FAIL b2b%0d_done timed out", r); end
      n = (wq_addr.size() < LEN) ? wq_addr.size() : LEN;
      tests++; if (n != LEN) begin fails++; $display("FAIL b2b%0d_count got=%0d exp=%0d", r, wq_addr.size(), LEN); end
      for (int i = 0; i < n; i++) begin
        got = {wq_addr[i], wq_data[i], wq_a[i]}; exp = exp_word(i);
        tests++; if (got !== exp) begin fails++; $display("FAIL b2b%0d_word%0d got=%h exp=%h", r, i, got, exp); end
        if (i > 0) begin
          tests++;
          if (wq_t[i] - wq_t[i-1] != exp_ticks(i)) begin
            fails++; $display("FAIL b2b%0d_ticks%0d got=%0d exp=%0d", r, i, wq_t[i] - wq_t[i-1], exp_ticks(i));
          end
        end
      end
      tests++; if (tout_err !== 1'b0) begin fails++; $display("FAIL b2b%0d_tout_clear got=%b exp=0", r, tout_err); end
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    setup(1'b0, 0, -1, 0);
    start_copy();
    for (int i = 0; i < 2000 && wq_addr.size() < 1; i++) @(negedge clk);
    #3 copy = 1'b1;
    @(negedge clk); #3 copy = 1'b0;
    wait_done(ok);
    repeat (30) @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL retrig_done timed out"); end
    tests++;
    if (wq_addr.size() != LEN || br_falls != 1 || busy !== 1'b0) begin
      fails++; $display("FAIL retrig_ignored writes=%0d br=%0d busy=%b exp %0d 1 0", wq_addr.size(), br_falls, busy, LEN);
    end
  endtask

  task automatic test_wait_states();
    bit ok; int n; logic [49:0] got, exp;
    setup(1'b0, 3, -1, 0);
    start_copy(); wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL wait_done timed out"); end
    n = (wq_addr.size() < LEN) ? wq_addr.size() : LEN;
    tests++; if (n != LEN) begin fails++; $display("FAIL wait_count got=%0d exp=%0d", wq_addr.size(), LEN); end
    for (int i = 0; i < n; i++) begin
      got = {wq_addr[i], wq_data[i], wq_a[i]}; exp = exp_word(i);
      tests++; if (got !== exp) begin fails++; $display("FAIL wait_word%0d got=%h exp=%h", i, got, exp); end
      if (i > 0) begin
        tests++;
        if (wq_t[i] - wq_t[i-1] != 7) begin fails++; $display("FAIL wait_ticks%0d got=%0d exp=7", i, wq_t[i] - wq_t[i-1]); end
      end
    end
    tests++; if (asn_falls != LEN || strb_bad != 0) begin
      fails++; $display("FAIL wait_strobes as_falls=%0d strb_bad=%0d exp %0d 0", asn_falls, strb_bad, LEN);
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int n; logic [58:0] got, exp; logic [49:0] gw, ew;
    setup(1'b0, 1, -1, 0);
    start_copy();
    for (int i = 0; i < 2000 && wq_addr.size() < 2; i++) @(negedge clk);
    tests++; if (wq_addr.size() < 2) begin fails++; $display("FAIL rmid_progress got=%0d exp>=2", wq_addr.size()); end
    #2 rst = 1'b1;
    #1;
    got = {BRn, BGACKn, ASn, UDSn, LDSn, RnW, A, buf_addr, buf_dout, buf_we, busy, tout_err};
    exp = {6'h3F, SRC, 11'd0, 16'd0, 3'd0};
    tests++; if (got !== exp) begin fails++; $display("FAIL rmid_outputs got=%h exp=%h", got, exp); end
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk); #3;
    setup(1'b0, 0, -1, 0);
    start_copy(); wait_done(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rmid_done timed out"); end
    n = (wq_addr.size() < LEN) ? wq_addr.size() : LEN;
    tests++; if (n != LEN) begin fails++; $display("FAIL rmid_count got=%0d exp=%0d", wq_addr.size(), LEN); end
    for (int i = 0; i < n; i++) begin
      gw = {wq_addr[i], wq_data[i], wq_a[i]}; ew = exp_word(i);
      tests++; if (gw !== ew) begin fails++; $display("FAIL rmid_word%0d got=%h exp=%h", i, gw, ew); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; copy = 1'b0;
    test_reset();
    test_basic();
    test_grant_wait();
    test_timeout();
    test_back_to_back();
    test_retrigger();
    test_wait_states();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
